// File: rtl/radar_sim_pkg.sv
// Shared radar simulation definitions: width helper, recorder state encoding
// and the overrun counter width.
package radar_sim_pkg;

   localparam int OVERRUN_W = 8;

   typedef enum logic {
      REC_IDLE    = 1'b0,
      REC_CAPTURE = 1'b1
   } rec_state_e;

   // Number of bits needed to represent value (at least 1 for value >= 1).
   function automatic int clogb2(input int value);
      int v;
      int n;
      v = value;
      n = 0;
      while (v > 0) begin
         n++;
         v = v >> 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/trig_edge_detect.sv
// Registers a level trigger and emits a single-cycle pulse on its rising edge.
module trig_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic trig_i,
   output logic rise_o
);

   logic trig_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) trig_q <= 1'b0;
      else       trig_q <= trig_i;
   end

   assign rise_o = trig_i & ~trig_q;

endmodule

// File: rtl/azimuth_signal_recorder.sv
// Captures SIZE serial samples after each trigger rising edge into a parallel
// frame and hands it out through a valid/ready output slot.
module azimuth_signal_recorder
   import radar_sim_pkg::*;
#(
   parameter int SIZE = 3200
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        EN,
   input  logic                        TRIG,
   input  logic                        SIGNAL,
   output logic [SIZE-1:0]             DATA,
   output logic [clogb2(SIZE+1)-1:0]   HIT_COUNT,
   output logic                        VALID,
   input  logic                        READY,
   output logic                        BUSY,
   output logic [OVERRUN_W-1:0]        OVERRUN_CNT
);

   localparam int IW = clogb2(SIZE - 1);
   localparam int HW = clogb2(SIZE + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

   rec_state_e             state_q;
   logic [IW-1:0]          idx_q;
   logic [HW-1:0]          hits_q;
   logic [SIZE-2:0]        cap_buf_q;
   logic [SIZE-1:0]        data_q;
   logic [HW-1:0]          hit_count_q;
   logic                   valid_q;
   logic [OVERRUN_W-1:0]   ovr_q;

   logic trig_edge;
   logic trig_rise;
   logic at_last;
   logic slot_free;
   logic sample_en;

   trig_edge_detect u_trig_edge (
      .clk_i  (CLK),
      .rst_i  (RST),
      .trig_i (TRIG),
      .rise_o (trig_edge)
   );

   assign trig_rise = trig_edge & EN;
   assign at_last   = (idx_q == LAST_IDX);
   assign slot_free = ~valid_q | READY;
   // The final sample bypasses the buffer, so only non-final, non-restart cycles store.
   assign sample_en = (state_q == REC_CAPTURE) & EN & ~trig_rise & ~at_last;

   // NOTE: the capture buffer has no reset; its contents are never observed
   // before a full frame has been written over it.
   always_ff @(posedge CLK) begin
      if (sample_en) cap_buf_q[idx_q] <= SIGNAL;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= REC_IDLE;
         idx_q       <= '0;
         hits_q      <= '0;
         data_q      <= '0;
         hit_count_q <= '0;
         valid_q     <= 1'b0;
         ovr_q       <= '0;
      end else begin
         if (valid_q && READY) valid_q <= 1'b0;

         case (state_q)
            REC_IDLE: begin
               if (trig_rise) begin
                  state_q <= REC_CAPTURE;
                  idx_q   <= '0;
                  hits_q  <= '0;
               end
            end

            REC_CAPTURE: begin
               if (!EN) begin
                  state_q <= REC_IDLE;
               end else if (at_last) begin
                  if (slot_free) begin
                     data_q      <= {SIGNAL, cap_buf_q};
                     hit_count_q <= hits_q + HW'(SIGNAL);
                     valid_q     <= 1'b1;
                  end else if (ovr_q != '1) begin
                     ovr_q <= ovr_q + OVERRUN_W'(1);
                  end
                  idx_q   <= '0;
                  hits_q  <= '0;
                  state_q <= trig_rise ? REC_CAPTURE : REC_IDLE;
               end else if (trig_rise) begin
                  idx_q  <= '0;
                  hits_q <= '0;
               end else begin
                  idx_q  <= idx_q + IW'(1);
                  hits_q <= hits_q + HW'(SIGNAL);
               end
            end

            default: state_q <= REC_IDLE;
         endcase
      end
   end

   assign DATA        = data_q;
   assign HIT_COUNT   = hit_count_q;
   assign VALID       = valid_q;
   assign BUSY        = (state_q == REC_CAPTURE);
   assign OVERRUN_CNT = ovr_q;

endmodule
